// File: rtl/hdbn_encoder_if.sv
// Stream-side bundle for the HDBn encoder: NRZ input strobe plus coded symbol / bipolar pulse output.
interface hdbn_encoder_if;
    logic       data_in;
    logic       in_valid;
    logic       ami_mode;
    logic [1:0] sym_out;
    logic       pos_out;
    logic       neg_out;
    logic       out_valid;

    modport master (
        output data_in, in_valid, ami_mode,
        input  sym_out, pos_out, neg_out, out_valid
    );

    modport slave (
        input  data_in, in_valid, ami_mode,
        output sym_out, pos_out, neg_out, out_valid
    );
endinterface

// File: rtl/hdbn_encoder.sv
// HDBn line encoder: V/B substitution over a ZERO_RUN-deep symbol line, then AMI polarity on exit.
module hdbn_encoder #(
    parameter int ZERO_RUN  = 4,
    parameter bit FIRST_V_B = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    hdbn_encoder_if.slave bus
);
    localparam int FW = $clog2(ZERO_RUN + 1);
    localparam int RW = $clog2(ZERO_RUN);
    localparam logic [FW-1:0] FILL_FULL = FW'(ZERO_RUN);
    localparam logic [RW-1:0] RUN_LAST  = RW'(ZERO_RUN - 1);
    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_ONE  = 2'b01;
    localparam logic [1:0] SYM_V    = 2'b11;
    localparam logic [1:0] SYM_B    = 2'b10;

    logic [1:0]    line_r [ZERO_RUN];
    logic [FW-1:0] fill_r;
    logic [RW-1:0] run_r;
    logic          parity_r;
    logic          first_v_r;
    logic          last_pol_r;
    logic [1:0]    sym_r;
    logic          pos_r;
    logic          neg_r;
    logic          valid_r;

    logic [1:0]    entry_s;
    logic [RW-1:0] run_nxt_s;
    logic          parity_nxt_s;
    logic          first_v_nxt_s;
    logic          b_ins_s;
    logic [1:0]    exit_s;
    logic          real_s;
    logic          pol_nxt_s;
    logic          pos_nxt_s;
    logic          neg_nxt_s;

    assign exit_s = line_r[ZERO_RUN-1];
    assign real_s = (fill_r == FILL_FULL);

    // Classify the incoming bit and decide on V/B substitution.
    always_comb begin
        entry_s       = SYM_ZERO;
        run_nxt_s     = run_r;
        parity_nxt_s  = parity_r;
        first_v_nxt_s = first_v_r;
        b_ins_s       = 1'b0;
        if (bus.ami_mode) begin
            entry_s      = bus.data_in ? SYM_ONE : SYM_ZERO;
            run_nxt_s    = '0;
            parity_nxt_s = 1'b0;
        end else if (bus.data_in) begin
            entry_s      = SYM_ONE;
            run_nxt_s    = '0;
            parity_nxt_s = ~parity_r;
        end else if (run_r == RUN_LAST) begin
            // The run's first zero is the oldest zero in the line and is moving into the last slot now.
            entry_s       = SYM_V;
            b_ins_s       = ~parity_r & (first_v_r | FIRST_V_B);
            run_nxt_s     = '0;
            parity_nxt_s  = 1'b0;
            first_v_nxt_s = 1'b1;
        end else begin
            entry_s   = SYM_ZERO;
            run_nxt_s = run_r + 1'b1;
        end
    end

    // Bipolar pulse for the exiting symbol; V repeats the previous mark's polarity.
    always_comb begin
        pol_nxt_s = last_pol_r;
        pos_nxt_s = 1'b0;
        neg_nxt_s = 1'b0;
        case (exit_s)
            SYM_ONE, SYM_B: begin
                pol_nxt_s = ~last_pol_r;
                pos_nxt_s = ~last_pol_r;
                neg_nxt_s = last_pol_r;
            end
            SYM_V: begin
                pos_nxt_s = last_pol_r;
                neg_nxt_s = ~last_pol_r;
            end
            default: begin
                pos_nxt_s = 1'b0;
                neg_nxt_s = 1'b0;
            end
        endcase
    end

    // Line shift, encoder state and registered outputs; everything freezes while in_valid is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < ZERO_RUN; k++) line_r[k] <= SYM_ZERO;
            fill_r     <= '0;
            run_r      <= '0;
            parity_r   <= 1'b0;
            first_v_r  <= 1'b0;
            last_pol_r <= 1'b0;
            sym_r      <= SYM_ZERO;
            pos_r      <= 1'b0;
            neg_r      <= 1'b0;
            valid_r    <= 1'b0;
        end else if (bus.in_valid) begin
            line_r[0] <= entry_s;
            for (int k = 1; k < ZERO_RUN; k++) line_r[k] <= line_r[k-1];
            if (b_ins_s) begin
                line_r[ZERO_RUN-1] <= SYM_B;
            end
            if (!real_s) begin
                fill_r <= fill_r + 1'b1;
            end
            run_r     <= run_nxt_s;
            parity_r  <= parity_nxt_s;
            first_v_r <= first_v_nxt_s;
            valid_r   <= real_s;
            if (real_s) begin
                sym_r      <= exit_s;
                pos_r      <= pos_nxt_s;
                neg_r      <= neg_nxt_s;
                last_pol_r <= pol_nxt_s;
            end
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign bus.sym_out   = sym_r;
    assign bus.pos_out   = pos_r;
    assign bus.neg_out   = neg_r;
    assign bus.out_valid = valid_r;
endmodule

// File: tb/tb_hdbn_encoder.sv
// Bench for hdbn_encoder: four configurations share one stimulus stream and are checked against a reference model.
module tb_hdbn_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic data_in = 1'b0;
    logic in_valid = 1'b0;
    logic ami_mode = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hdbn_encoder_if if0 ();
    hdbn_encoder_if if1 ();
    hdbn_encoder_if if2 ();
    hdbn_encoder_if if3 ();

    assign if0.data_in = data_in;  assign if0.in_valid = in_valid;  assign if0.ami_mode = ami_mode;
    assign if1.data_in = data_in;  assign if1.in_valid = in_valid;  assign if1.ami_mode = ami_mode;
    assign if2.data_in = data_in;  assign if2.in_valid = in_valid;  assign if2.ami_mode = ami_mode;
    assign if3.data_in = data_in;  assign if3.in_valid = in_valid;  assign if3.ami_mode = ami_mode;

    hdbn_encoder #(.ZERO_RUN(4), .FIRST_V_B(1'b0)) u_enc0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    hdbn_encoder #(.ZERO_RUN(4), .FIRST_V_B(1'b1)) u_enc1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    hdbn_encoder #(.ZERO_RUN(3), .FIRST_V_B(1'b0)) u_enc2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    hdbn_encoder #(.ZERO_RUN(8), .FIRST_V_B(1'b1)) u_enc3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    logic [4:0] obs [4];
    assign obs[0] = {if0.out_valid, if0.sym_out, if0.pos_out, if0.neg_out};
    assign obs[1] = {if1.out_valid, if1.sym_out, if1.pos_out, if1.neg_out};
    assign obs[2] = {if2.out_valid, if2.sym_out, if2.pos_out, if2.neg_out};
    assign obs[3] = {if3.out_valid, if3.sym_out, if3.pos_out, if3.neg_out};

    typedef struct {
        time        t;
        logic       v;
        logic [1:0] sym;
        logic       pos;
        logic       neg;
    } exp_t;

    exp_t       exp_q [4][$];
    logic [3:0] cap0 [$];
    logic [3:0] cap1 [$];
    exp_t       mon_e;

    int         zr_c  [4] = '{4, 4, 3, 8};
    logic       fvb_c [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] m_line [4][8];
    int         m_fill [4];
    int         m_run  [4];
    logic       m_par  [4];
    logic       m_fv   [4];
    logic       m_pol  [4];
    logic [1:0] m_sym  [4];
    logic       m_pos  [4];
    logic       m_neg  [4];

    // Reference model: one cycle of every configuration, expected outputs queued for the edge just ahead.
    task automatic model_step(input logic r, input logic v, input logic b, input logic a);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            int z;
            logic [1:0] ex;
            logic [1:0] s;
            logic dob;
            z   = zr_c[i];
            e.t = $time;
            e.v = 1'b0;
            dob = 1'b0;
            if (!r) begin
                for (int k = 0; k < 8; k++) m_line[i][k] = 2'b00;
                m_fill[i] = 0; m_run[i] = 0; m_par[i] = 1'b0; m_fv[i] = 1'b0; m_pol[i] = 1'b0;
                m_sym[i] = 2'b00; m_pos[i] = 1'b0; m_neg[i] = 1'b0;
            end else if (v) begin
                ex = m_line[i][z-1];
                if (m_fill[i] == z) begin
                    e.v = 1'b1;
                    m_sym[i] = ex;
                    if (ex == 2'b01 || ex == 2'b10) begin
                        m_pol[i] = ~m_pol[i];
                        m_pos[i] = m_pol[i];
                        m_neg[i] = ~m_pol[i];
                    end else if (ex == 2'b11) begin
                        m_pos[i] = m_pol[i];
                        m_neg[i] = ~m_pol[i];
                    end else begin
                        m_pos[i] = 1'b0;
                        m_neg[i] = 1'b0;
                    end
                end
                if (b) begin
                    s = 2'b01; m_run[i] = 0; m_par[i] = ~m_par[i];
                end else if (!a && m_run[i] == z - 1) begin
                    s = 2'b11;
                    dob = !m_par[i] && (m_fv[i] || fvb_c[i]);
                    m_run[i] = 0; m_par[i] = 1'b0; m_fv[i] = 1'b1;
                end else begin
                    s = 2'b00; m_run[i] = m_run[i] + 1;
                end
                if (a) begin
                    m_run[i] = 0; m_par[i] = 1'b0;
                end
                for (int k = z - 1; k > 0; k--) m_line[i][k] = m_line[i][k-1];
                m_line[i][0] = s;
                if (dob) m_line[i][z-1] = 2'b10;
                if (m_fill[i] < z) m_fill[i] = m_fill[i] + 1;
            end
            e.sym = m_sym[i]; e.pos = m_pos[i]; e.neg = m_neg[i];
            exp_q[i].push_back(e);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic b, input logic a);
        @(negedge clk);
        rst_n = r; in_valid = v; data_in = b; ami_mode = a;
        model_step(r, v, b, a);
    endtask

    // Scoreboard: compare each DUT against the entry queued before the previous rising edge.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (exp_q[i].size() > 0 && exp_q[i][0].t < $time) begin
                mon_e = exp_q[i].pop_front();
                checks++;
                if (obs[i] !== {mon_e.v, mon_e.sym, mon_e.pos, mon_e.neg}) begin
                    errors++;
                    $display("FAIL scoreboard dut%0d t=%0t got valid/sym/pos/neg=%b expected %b", i, $time, obs[i],
                             {mon_e.v, mon_e.sym, mon_e.pos, mon_e.neg});
                end
            end
        end
        if (if0.out_valid) cap0.push_back(obs[0][3:0]);
        if (if1.out_valid) cap1.push_back(obs[1][3:0]);
    end

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cap0.delete();
        cap1.delete();
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n, input logic a);
        for (int j = n - 1; j >= 0; j--) drive(1'b1, 1'b1, bits[j], a);
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs[i] !== 5'b00000) begin
                errors++;
                $display("FAIL reset_state dut%0d got %b expected 00000", i, obs[i]);
            end
        end
    endtask

    task automatic test_hdb3_runs();
        logic [3:0] exp_a [9] = '{4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b1110,
                                  4'b1001, 4'b0000, 4'b0000, 4'b1101};
        do_reset();
        send_bits(16'b1_0000_0000, 9, 1'b0);
        send_bits(16'b1111, 4, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 9; j++) begin
            checks++;
            if (j >= cap0.size() || cap0[j] !== exp_a[j]) begin
                errors++;
                $display("FAIL hdb3_runs sym%0d got %b expected %b", j, (j < cap0.size()) ? cap0[j] : 4'bxxxx, exp_a[j]);
            end
        end
    endtask

    task automatic test_first_v();
        logic [3:0] exp0 [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b1101};
        logic [3:0] exp1 [4] = '{4'b1010, 4'b0000, 4'b0000, 4'b1110};
        do_reset();
        send_bits(16'b0000_1111, 8, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (j >= cap0.size() || cap0[j] !== exp0[j]) begin
                errors++;
                $display("FAIL first_v_nob sym%0d got %b expected %b", j, (j < cap0.size()) ? cap0[j] : 4'bxxxx, exp0[j]);
            end
            checks++;
            if (j >= cap1.size() || cap1[j] !== exp1[j]) begin
                errors++;
                $display("FAIL first_v_b sym%0d got %b expected %b", j, (j < cap1.size()) ? cap1[j] : 4'bxxxx, exp1[j]);
            end
        end
    endtask

    task automatic test_ami();
        logic [3:0] exp_a [8] = '{4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0101};
        logic [7:0] pat = 8'b1000_0001;
        do_reset();
        for (int j = 0; j < 8; j++) begin
            drive(1'b1, 1'b1, pat[7-j], 1'b1);
            if (j == 3 || j == 4) begin
                @(posedge clk);
                #1;
                checks++;
                if (if0.out_valid !== (j == 4)) begin
                    errors++;
                    $display("FAIL ami_first_valid bit%0d got %b expected %b", j + 1, if0.out_valid, (j == 4));
                end
            end
        end
        send_bits(16'b1111, 4, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (j >= cap0.size() || cap0[j] !== exp_a[j]) begin
                errors++;
                $display("FAIL ami_stream sym%0d got %b expected %b", j, (j < cap0.size()) ? cap0[j] : 4'bxxxx, exp_a[j]);
            end
        end
    endtask

    task automatic test_gaps();
        logic [3:0] exp_a [5] = '{4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b1110};
        do_reset();
        send_bits(16'b100, 3, 1'b0);
        for (int j = 0; j < 3; j++) drive(1'b1, 1'b0, 1'b1, 1'b0);
        send_bits(16'b00_1111, 6, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (j >= cap0.size() || cap0[j] !== exp_a[j]) begin
                errors++;
                $display("FAIL gap_stream sym%0d got %b expected %b", j, (j < cap0.size()) ? cap0[j] : 4'bxxxx, exp_a[j]);
            end
        end
    endtask

    task automatic test_random_reset();
        logic a;
        a = 1'b0;
        do_reset();
        for (int j = 0; j < 400; j++) begin
            if ($urandom_range(0, 29) == 0) a = ~a;
            drive(1'b1, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 3), a);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs[i] !== 5'b00000) begin
                errors++;
                $display("FAIL midrun_reset dut%0d got %b expected 00000", i, obs[i]);
            end
        end
        for (int j = 0; j < 9; j++) begin
            drive(1'b1, 1'b1, ($urandom_range(0, 1) == 1), 1'b0);
            @(posedge clk);
            #1;
            checks++;
            if (if3.out_valid !== (j == 8) || if2.out_valid !== (j >= 3)) begin
                errors++;
                $display("FAIL priming bit%0d got zr8=%b zr3=%b expected zr8=%b zr3=%b", j + 1,
                         if3.out_valid, if2.out_valid, (j == 8), (j >= 3));
            end
        end
        for (int j = 0; j < 400; j++) begin
            drive(1'b1, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2), ($urandom_range(0, 49) == 0));
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_hdb3_runs();
        test_first_v();
        test_ami();
        test_gaps();
        test_random_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
